// File: rtl/updown_sweep_controller_if.sv
// Interface: updown_sweep_controller_if
// Purpose:
//   Groups the run-control inputs and the status outputs of the up/down
//   sweep controller into a single bundle.
// Signals:
//   start, abort          run requests (start sampled only when idle)
//   lo, hi                sweep bounds, W bits
//   dwell                 extra hold cycles at each bound, DW bits
//   n_sweeps              sweeps per run (0 = continuous), NW bits
//   Q                     current count
//   Up_Down               direction of the next move (1 = up)
//   busy, done, cfg_err   run status; done and cfg_err are single-cycle pulses
//   sweeps                completed sweeps in the current run
// Modports:
//   master  drives requests and configuration, observes status
//   slave   the controller itself
interface updown_sweep_controller_if #(
    parameter int W  = 4,
    parameter int DW = 4,
    parameter int NW = 4
);
    logic          start;
    logic          abort;
    logic [W-1:0]  lo;
    logic [W-1:0]  hi;
    logic [DW-1:0] dwell;
    logic [NW-1:0] n_sweeps;
    logic [W-1:0]  Q;
    logic          Up_Down;
    logic          busy;
    logic          done;
    logic [NW-1:0] sweeps;
    logic          cfg_err;

    modport master (
        output start, abort, lo, hi, dwell, n_sweeps,
        input  Q, Up_Down, busy, done, sweeps, cfg_err
    );

    modport slave (
        input  start, abort, lo, hi, dwell, n_sweeps,
        output Q, Up_Down, busy, done, sweeps, cfg_err
    );
endinterface

// File: rtl/updown_sweep_controller.sv
// Module: updown_sweep_controller
// Purpose:
//   Sequencer that sweeps an unsigned count as a triangle lo -> hi -> lo,
//   holding for an optional number of dwell cycles at each bound. A run
//   covers a programmed number of sweeps, or runs forever when that number
//   is zero. All outputs are registered.
// Ports:
//   C     clock, rising edge
//   CLR   asynchronous active-high reset
//   bus   slave side of updown_sweep_controller_if (requests, configuration
//         and status; see the interface file for the individual signals)
module updown_sweep_controller #(
    parameter int W  = 4,
    parameter int DW = 4,
    parameter int NW = 4
) (
    input  logic                         C,
    input  logic                         CLR,
    updown_sweep_controller_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DWELL_HI,
        DOWN,
        DWELL_LO
    } state_t;

    state_t        state, state_next;

    logic [W-1:0]  q, q_next;
    logic          up_down, up_down_next;
    logic          busy, busy_next;
    logic          done, done_next;
    logic          cfg_err, cfg_err_next;
    logic [NW-1:0] sweeps, sweeps_next;

    // Configuration captured at start so that input changes mid-run are ignored.
    logic [W-1:0]  lo_r, lo_next;
    logic [W-1:0]  hi_r, hi_next;
    logic [DW-1:0] dwell_r, dwell_next;
    logic [NW-1:0] n_r, n_next;

    // Remaining hold cycles while parked at a bound.
    logic [DW-1:0] dcnt, dcnt_next;

    logic [W-1:0]  q_inc;
    logic [W-1:0]  q_dec;
    logic [NW-1:0] sweeps_inc;

    assign q_inc      = q + W'(1);
    assign q_dec      = q - W'(1);
    assign sweeps_inc = sweeps + NW'(1);

    assign bus.Q       = q;
    assign bus.Up_Down = up_down;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.sweeps  = sweeps;
    assign bus.cfg_err = cfg_err;

    // State, outputs and latched configuration all live in one register bank.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            q       <= '0;
            up_down <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            sweeps  <= '0;
            lo_r    <= '0;
            hi_r    <= '0;
            dwell_r <= '0;
            n_r     <= '0;
            dcnt    <= '0;
        end else begin
            state   <= state_next;
            q       <= q_next;
            up_down <= up_down_next;
            busy    <= busy_next;
            done    <= done_next;
            cfg_err <= cfg_err_next;
            sweeps  <= sweeps_next;
            lo_r    <= lo_next;
            hi_r    <= hi_next;
            dwell_r <= dwell_next;
            n_r     <= n_next;
            dcnt    <= dcnt_next;
        end
    end

    // Next-state logic. Everything holds by default; done and cfg_err are
    // pulses and therefore default low. The bound tests look at the value
    // the count is about to take, so the turn-around happens on the same
    // edge that lands on the bound and the count never steps past it.
    always_comb begin
        state_next   = state;
        q_next       = q;
        up_down_next = up_down;
        busy_next    = busy;
        done_next    = 1'b0;
        cfg_err_next = 1'b0;
        sweeps_next  = sweeps;
        lo_next      = lo_r;
        hi_next      = hi_r;
        dwell_next   = dwell_r;
        n_next       = n_r;
        dcnt_next    = dcnt;

        if (state != IDLE && bus.abort) begin
            state_next = IDLE;
            busy_next  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort in the same cycle suppresses the start request
                    if (bus.start && !bus.abort) begin
                        if (bus.lo < bus.hi) begin
                            lo_next      = bus.lo;
                            hi_next      = bus.hi;
                            dwell_next   = bus.dwell;
                            n_next       = bus.n_sweeps;
                            q_next       = bus.lo;
                            up_down_next = 1'b1;
                            sweeps_next  = '0;
                            busy_next    = 1'b1;
                            state_next   = UP;
                        end else begin
                            cfg_err_next = 1'b1;
                        end
                    end
                end

                UP: begin
                    q_next = q_inc;
                    if (q_inc == hi_r) begin
                        up_down_next = 1'b0;
                        if (dwell_r != '0) begin
                            dcnt_next  = dwell_r;
                            state_next = DWELL_HI;
                        end else begin
                            state_next = DOWN;
                        end
                    end
                end

                DWELL_HI: begin
                    if (dcnt <= DW'(1)) begin
                        state_next = DOWN;
                    end else begin
                        dcnt_next = dcnt - DW'(1);
                    end
                end

                DOWN: begin
                    q_next = q_dec;
                    if (q_dec == lo_r) begin
                        sweeps_next = sweeps_inc;
                        if (n_r != '0 && sweeps_inc == n_r) begin
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end else begin
                            up_down_next = 1'b1;
                            if (dwell_r != '0) begin
                                dcnt_next  = dwell_r;
                                state_next = DWELL_LO;
                            end else begin
                                state_next = UP;
                            end
                        end
                    end
                end

                DWELL_LO: begin
                    if (dcnt <= DW'(1)) begin
                        state_next = UP;
                    end else begin
                        dcnt_next = dcnt - DW'(1);
                    end
                end

                default: begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_sweep_controller.sv
// Testbench: tb_updown_sweep_controller
// Purpose:
//   Drives the sweep controller through directed and randomized runs and
//   compares every cycle against a trajectory model built from the sweep
//   rules (ramp lists and dwell repeats), plus reset, config-error, abort
//   and mid-run reset scenarios.
module tb_updown_sweep_controller;

    localparam int W  = 4;
    localparam int DW = 4;
    localparam int NW = 4;

    logic C;
    logic CLR;

    updown_sweep_controller_if #(.W(W), .DW(DW), .NW(NW)) bus ();

    updown_sweep_controller #(.W(W), .DW(DW), .NW(NW)) dut (
        .C   (C),
        .CLR (CLR),
        .bus (bus)
    );

    typedef struct {
        int q;
        bit ud;
        bit busy;
        bit done;
        int sw;
    } exp_t;

    exp_t exp_q[$];

    int checks;
    int failures;

    // Values the controller should hold while idle after the latest run.
    int idle_q;
    bit idle_ud;
    int idle_sw;

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic applyStimulus(input logic st, input logic ab,
                                 input int l, input int h, input int d, input int n);
        bus.start    = st;
        bus.abort    = ab;
        bus.lo       = 4'(l);
        bus.hi       = 4'(h);
        bus.dwell    = 4'(d);
        bus.n_sweeps = 4'(n);
    endtask

    function automatic void push(input int q, input bit ud, input bit busy,
                                 input bit done, input int sw);
        exp_t e;
        e.q    = q;
        e.ud   = ud;
        e.busy = busy;
        e.done = done;
        e.sw   = sw % 16;
        exp_q.push_back(e);
    endfunction

    // Per-cycle trajectory after the start edge: first lo, then for each
    // sweep the rising ramp, hi shown dwell+1 times, the falling ramp, and
    // lo shown dwell+1 times (or once with done on the final sweep, then idle).
    function automatic void build_model(input int lo, input int hi, input int dw,
                                        input int n, input int limit);
        int s;
        exp_q.delete();
        s = 0;
        push(lo, 1, 1, 0, 0);
        while (exp_q.size() < limit) begin
            for (int v = lo + 1; v < hi; v++) push(v, 1, 1, 0, s);
            for (int d = 0; d <= dw; d++) push(hi, 0, 1, 0, s);
            for (int v = hi - 1; v > lo; v--) push(v, 0, 1, 0, s);
            s++;
            if (n != 0 && s == n) begin
                push(lo, 0, 0, 1, s);
                push(lo, 0, 0, 0, s);
                break;
            end
            for (int d = 0; d <= dw; d++) push(lo, 1, 1, 0, s);
        end
    endfunction

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0, 0, 0);
        CLR = 1'b1;
        @(negedge C);
        @(negedge C);
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want 0 1 0 0 0 0",
                     bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err);
        end
        CLR = 1'b0;
        @(negedge C);
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_release got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want 0 1 0 0 0 0",
                     bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err);
        end
        idle_q  = 0;
        idle_ud = 1;
        idle_sw = 0;
    endtask

    // Full runs: directed corner configurations then random ones. While the
    // run is active, start is toggled and the config inputs scrambled; none
    // of that may disturb the run.
    task automatic test_sweeps();
        int lo, hi, dw, n, last;
        int dlo[4] = '{2, 0, 0, 7};
        int dhi[4] = '{5, 2, 15, 8};
        int ddw[4] = '{0, 2, 1, 0};
        int dn[4]  = '{1, 2, 1, 3};
        exp_t e;
        for (int r = 0; r < 14; r++) begin
            if (r < 4) begin
                lo = dlo[r]; hi = dhi[r]; dw = ddw[r]; n = dn[r];
            end else begin
                lo = $urandom_range(0, 14);
                hi = $urandom_range(lo + 1, 15);
                dw = $urandom_range(0, 3);
                n  = $urandom_range(1, 3);
            end
            build_model(lo, hi, dw, n, 100000);
            last = exp_q.size() - 2;
            @(negedge C);
            applyStimulus(1, 0, lo, hi, dw, n);
            for (int k = 0; k < exp_q.size(); k++) begin
                @(negedge C);
                e = exp_q[k];
                checks++;
                if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'(e.q), e.ud, e.busy, e.done, 4'(e.sw), 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL sweep run=%0d k=%0d got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=0",
                             r, k, bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err,
                             e.q, e.ud, e.busy, e.done, e.sw);
                end
                if (k < last)
                    applyStimulus(1'($urandom_range(0, 1)), 0, $urandom_range(0, 15),
                                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
                else
                    applyStimulus(0, 0, 0, 0, 0, 0);
            end
            e = exp_q[exp_q.size() - 1];
            idle_q  = e.q;
            idle_ud = e.ud;
            idle_sw = e.sw;
        end
    endtask

    task automatic test_cfg_err();
        int clo[6];
        int chi[6];
        clo[0] = 5;  chi[0] = 5;
        clo[1] = 7;  chi[1] = 3;
        clo[2] = 0;  chi[2] = 0;
        clo[3] = 15; chi[3] = 0;
        for (int i = 4; i < 6; i++) begin
            chi[i] = $urandom_range(0, 15);
            clo[i] = $urandom_range(chi[i], 15);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge C);
            applyStimulus(1, 0, clo[i], chi[i], 1, 1);
            @(negedge C);
            applyStimulus(0, 0, 0, 0, 0, 0);
            checks++;
            if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'(idle_q), idle_ud, 1'b0, 1'b0, 4'(idle_sw), 1'b1}) begin
                failures++;
                $display("[TB] FAIL cfg_err_pulse lo=%0d hi=%0d got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want Q=%0d ud=%0b busy=0 done=0 sweeps=%0d cfg_err=1",
                         clo[i], chi[i], bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err,
                         idle_q, idle_ud, idle_sw);
            end
            @(negedge C);
            checks++;
            if ({bus.Q, bus.busy, bus.sweeps, bus.cfg_err} !== {4'(idle_q), 1'b0, 4'(idle_sw), 1'b0}) begin
                failures++;
                $display("[TB] FAIL cfg_err_clear lo=%0d hi=%0d got Q=%0d busy=%0b sweeps=%0d cfg_err=%0b, want Q=%0d busy=0 sweeps=%0d cfg_err=0",
                         clo[i], chi[i], bus.Q, bus.busy, bus.sweeps, bus.cfg_err, idle_q, idle_sw);
            end
        end
    endtask

    // Continuous mode at the top of the range: must stay within [13,15],
    // wrap the sweep counter and never pulse done; abort ends the run.
    task automatic test_continuous();
        exp_t e;
        build_model(13, 15, 0, 0, 80);
        @(negedge C);
        applyStimulus(1, 0, 13, 15, 0, 0);
        for (int k = 0; k < 80; k++) begin
            @(negedge C);
            e = exp_q[k];
            checks++;
            if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'(e.q), e.ud, e.busy, e.done, 4'(e.sw), 1'b0}) begin
                failures++;
                $display("[TB] FAIL continuous k=%0d got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d, want Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d",
                         k, bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps,
                         e.q, e.ud, e.busy, e.done, e.sw);
            end
            checks++;
            if (bus.Q < 4'd13 || bus.Q > 4'd15 || bus.done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL continuous_range k=%0d got Q=%0d done=%0b, want Q in 13..15 done=0",
                         k, bus.Q, bus.done);
            end
            if (k == 79)
                applyStimulus(0, 1, 0, 0, 0, 0);
            else
                applyStimulus(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        end
        @(negedge C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        e = exp_q[79];
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps} !== {4'(e.q), e.ud, 1'b0, 1'b0, 4'(e.sw)}) begin
            failures++;
            $display("[TB] FAIL continuous_abort got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d, want Q=%0d ud=%0b busy=0 done=0 sweeps=%0d",
                     bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, e.q, e.ud, e.sw);
        end
        idle_q  = e.q;
        idle_ud = e.ud;
        idle_sw = e.sw;
    endtask

    task automatic test_abort();
        exp_t e;
        bit   hit;
        hit = 0;
        build_model(2, 6, 0, 1, 100000);
        @(negedge C);
        applyStimulus(1, 0, 2, 6, 0, 1);
        for (int k = 0; k < exp_q.size() && !hit; k++) begin
            @(negedge C);
            e = exp_q[k];
            checks++;
            if ({bus.Q, bus.Up_Down, bus.busy} !== {4'(e.q), e.ud, e.busy}) begin
                failures++;
                $display("[TB] FAIL abort_run k=%0d got Q=%0d ud=%0b busy=%0b, want Q=%0d ud=%0b busy=%0b",
                         k, bus.Q, bus.Up_Down, bus.busy, e.q, e.ud, e.busy);
            end
            if (e.q == 4 && !e.ud && e.busy) begin
                hit = 1;
                applyStimulus(0, 1, 0, 0, 0, 0);
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0);
            end
        end
        // three idle cycles: plain, abort alone in idle, start with abort
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            checks++;
            if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL abort_hold i=%0d got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want Q=4 ud=0 busy=0 done=0 sweeps=0 cfg_err=0",
                         i, bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err);
            end
            if (i == 0)
                applyStimulus(0, 1, 1, 3, 0, 1);
            else if (i == 1)
                applyStimulus(1, 1, 1, 3, 0, 1);
            else
                applyStimulus(1, 0, 1, 3, 0, 1);
        end
        @(negedge C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.sweeps} !== {4'd1, 1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("[TB] FAIL abort_restart got Q=%0d ud=%0b busy=%0b sweeps=%0d, want Q=1 ud=1 busy=1 sweeps=0",
                     bus.Q, bus.Up_Down, bus.busy, bus.sweeps);
        end
        @(negedge C);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checks++;
        if (bus.Q !== 4'd2) begin
            failures++;
            $display("[TB] FAIL abort_restart_step got Q=%0d, want Q=2", bus.Q);
        end
        @(negedge C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.Q, bus.busy} !== {4'd2, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_restart_stop got Q=%0d busy=%0b, want Q=2 busy=0", bus.Q, bus.busy);
        end
    endtask

    task automatic test_clr_midrun();
        @(negedge C);
        applyStimulus(1, 0, 3, 9, 1, 2);
        @(negedge C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (4) @(negedge C);
        #2;
        CLR = 1'b1;
        #1;
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err} !== {4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL clr_async got Q=%0d ud=%0b busy=%0b done=%0b sweeps=%0d cfg_err=%0b, want 0 1 0 0 0 0",
                     bus.Q, bus.Up_Down, bus.busy, bus.done, bus.sweeps, bus.cfg_err);
        end
        @(negedge C);
        CLR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge C);
            checks++;
            if ({bus.Q, bus.busy} !== {4'd0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL clr_stays_idle i=%0d got Q=%0d busy=%0b, want Q=0 busy=0", i, bus.Q, bus.busy);
            end
        end
        applyStimulus(1, 0, 3, 9, 1, 2);
        @(negedge C);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checks++;
        if ({bus.Q, bus.Up_Down, bus.busy, bus.sweeps} !== {4'd3, 1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("[TB] FAIL clr_restart got Q=%0d ud=%0b busy=%0b sweeps=%0d, want Q=3 ud=1 busy=1 sweeps=0",
                     bus.Q, bus.Up_Down, bus.busy, bus.sweeps);
        end
        @(negedge C);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_restart_abort got busy=%0b, want busy=0", bus.busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        CLR      = 1'b1;
        test_reset();
        test_sweeps();
        test_cfg_err();
        test_continuous();
        test_abort();
        test_clr_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
